// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: state encodings and default bit period.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, async active-low reset.
module sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling on a synchronized line.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);

  state_t            state;
  logic              rxs;
  logic              armed;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
`ifdef UART_RX_PARITY_EN
  logic              par_bit;
`endif

  sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      tick      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      ready     <= 1'b1;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tick    <= '0;
          bit_cnt <= '0;
          // A low line only starts a frame once it has been seen high.
          if (armed && !rxs) begin
            state <= START;
            armed <= 1'b0;
          end else if (rxs) begin
            armed <= 1'b1;
          end
        end
        START: begin
          if (tick == HALF_TICK) begin
            tick <= '0;
            if (!rxs) begin
              state <= DATA;
              ready <= 1'b0;
            end else begin
              state <= IDLE;
              armed <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick == LAST_TICK) begin
            tick    <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick == LAST_TICK) begin
            tick    <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
`endif
        STOP: begin
          if (tick == LAST_TICK) begin
            tick      <= '0;
            data      <= shreg;
            frame_err <= ~rxs;
            ready     <= 1'b1;
            // Arming from the stop bit itself lets a start edge follow immediately,
            // while a low (break) stop keeps the receiver disarmed.
            armed     <= rxs;
            state     <= IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err <= ^{shreg, par_bit};
`endif
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int STOP_MID = (9 + NPAR) * CPB + CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .ready     (ready),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int low_cnt = 0;
  int last_rise = 0;
  int start_cyc = 0;
  logic prev_ready = 1'b1;

  // Reference model: outputs a receiver must show after the last completed frame
  logic [7:0] exp_data = 8'h00;
  logic       exp_ferr = 1'b0;
  logic       exp_perr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready && !prev_ready) begin
      rise_cnt  <= rise_cnt + 1;
      last_rise <= cyc;
    end
    if (!ready) low_cnt <= low_cnt + 1;
    prev_ready <= ready;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (NPAR != 0) send_bit(par);
    send_bit(stop);
    exp_data = b;
    exp_ferr = (stop == 1'b0);
    exp_perr = ($countones({b, par}) % 2) == 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd = 1'b1;
    wait_cycles(3);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    rst = 1'b1;
    wait_cycles(8);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", ready); end
  endtask

  task automatic test_frame_a5();
    int r0;
    int off;
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    off = last_rise - start_cyc;
    checks++; if (data !== exp_data) begin errors++; $display("FAIL a5_data: got %h expected %h", data, exp_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b expected 0", frame_err); end
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL a5_rises: got %0d expected 1", rise_cnt - r0); end
    checks++; if (off < STOP_MID - 2 || off > STOP_MID + 4) begin
      errors++; $display("FAIL a5_ready_time: got offset %0d expected %0d..%0d", off, STOP_MID - 2, STOP_MID + 4);
    end
    wait_cycles(4);
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] b;
      logic       p;
      int         r0;
      b  = 8'($urandom);
      p  = 1'($urandom);
      r0 = rise_cnt;
      send_frame(b, 1'b1, p);
      checks++; if (data !== exp_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, data, exp_data); end
      checks++; if (frame_err !== exp_ferr) begin errors++; $display("FAIL rnd_ferr[%0d]: got %b expected %b", n, frame_err, exp_ferr); end
      checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL rnd_rises[%0d]: got %0d expected 1", n, rise_cnt - r0); end
`ifdef UART_RX_PARITY_EN
      checks++; if (parity_err !== exp_perr) begin errors++; $display("FAIL rnd_perr[%0d]: got %b expected %b", n, parity_err, exp_perr); end
`endif
      wait_cycles(int'($urandom_range(0, 10)));
    end
  endtask

  task automatic test_glitch();
    int l0;
    int r0;
    l0 = low_cnt;
    r0 = rise_cnt;
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready: got %b expected 1", ready); end
    checks++; if (low_cnt != l0) begin errors++; $display("FAIL glitch_ready_low: got %0d low cycles expected 0", low_cnt - l0); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_data: got %h expected %h", data, exp_data); end
    checks++; if (rise_cnt != r0) begin errors++; $display("FAIL glitch_rises: got %0d expected 0", rise_cnt - r0); end
    // A real frame right after the rejected glitch must still be received
    send_frame(8'($urandom), 1'b1, 1'b0);
    checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_next_data: got %h expected %h", data, exp_data); end
  endtask

  task automatic test_break();
    int r0;
    int l0;
    logic [7:0] b;
    r0 = rise_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    l0 = low_cnt;
    wait_cycles(40);
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL brk_data: got %h expected 3c", data); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL brk_ferr: got %b expected 1", frame_err); end
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL brk_rises: got %0d expected 1", rise_cnt - r0); end
    checks++; if (low_cnt != l0) begin errors++; $display("FAIL brk_phantom: got %0d low cycles expected 0", low_cnt - l0); end
    rxd = 1'b1;
    wait_cycles(20);
    b = 8'($urandom);
    send_frame(b, 1'b1, ^b);
    checks++; if (data !== exp_data) begin errors++; $display("FAIL brk_next_data: got %h expected %h", data, exp_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL brk_next_ferr: got %b expected 0", frame_err); end
    checks++; if (rise_cnt - r0 != 2) begin errors++; $display("FAIL brk_next_rises: got %0d expected 2", rise_cnt - r0); end
    wait_cycles(4);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rise_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", data); end
    send_frame(8'hFF, 1'b1, 1'b0);
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b expected 0", frame_err); end
    checks++; if (rise_cnt - r0 != 2) begin errors++; $display("FAIL b2b_rises: got %0d expected 2", rise_cnt - r0); end
    wait_cycles(4);
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    int r0;
    b = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rxd = b[3];
    wait_cycles(CPB / 2);
    rst = 1'b0;
    rxd = 1'b1;
    exp_data = 8'h00;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    wait_cycles(3);
    checks++; if (data !== exp_data) begin errors++; $display("FAIL rstmid_data: got %h expected %h", data, exp_data); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    checks++; if (frame_err !== exp_ferr) begin errors++; $display("FAIL rstmid_ferr: got %b expected %b", frame_err, exp_ferr); end
    rst = 1'b1;
    wait_cycles(20);
    r0 = rise_cnt;
    send_frame(8'h81, 1'b1, 1'b0);
    checks++; if (data !== 8'h81) begin errors++; $display("FAIL rstmid_next: got %h expected 81", data); end
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL rstmid_rises: got %0d expected 1", rise_cnt - r0); end
    wait_cycles(4);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b0);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %b expected 1", parity_err); end
    send_frame(8'h01, 1'b1, 1'b1);
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good: got %b expected 0", parity_err); end
    checks++; if (data !== 8'h01) begin errors++; $display("FAIL par_data: got %h expected 01", data); end
    wait_cycles(4);
  endtask
`endif

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_frame_a5();
    test_random_frames();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_byte();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, 434, clk cycles per serial bit (legal range >= 4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (clear on rst low, independent of clk).
REQ-004 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port data  output  8  last received byte, registered.
REQ-006 SHALL have port ready  output  1  high when idle or byte complete; low while a byte is in reception (drives valid_gen's ready).
REQ-007 SHALL have port frame_err  output  1  registered; high if the last byte's stop bit sampled 0.

Function
REQ-008 SHALL pass rxd through a 2-flop synchronizer (flops reset to 1); all FSM decisions use the synchronized bit rxs (2-cycle latency).
REQ-009 SHALL implement states IDLE, START, DATA, STOP; bit counter 0..7; tick counter of width $clog2(CLKS_PER_BIT).
REQ-010 IDLE: SHALL arm only after rxs has been 1 for at least one cycle; when armed and rxs=0, go to START with tick counter cleared.
REQ-011 START: at tick CLKS_PER_BIT/2-1 (integer division), if rxs=0 go to DATA with tick counter cleared, else return to IDLE (glitch rejected; no output changes).
REQ-012 ready SHALL fall on the START->DATA transition, never on a rejected glitch.
REQ-013 DATA: at each tick CLKS_PER_BIT-1 sample rxs into the shift register LSB first, clear tick counter; after bit 7 go to STOP.
REQ-014 STOP: at tick CLKS_PER_BIT-1, in the same cycle: data <= shift register, frame_err <= ~rxs, ready <= 1; go to IDLE.
REQ-015 data and frame_err SHALL hold their value between stop samples.
REQ-016 After a stop bit sampled 0 (break/frame error), IDLE SHALL stay disarmed until rxs returns to 1 (REQ-010); no phantom byte.
REQ-017 A start edge arriving in the cycle after the stop sample SHALL be accepted (back-to-back bytes, no extra idle required).
REQ-018 ready rising edge SHALL occur exactly one clk after the stop-sample tick count is reached, giving valid_gen one rising edge per byte.

Reset
REQ-019 On rst low: state IDLE, disarmed, counters 0, shift register 0, data 8'h00, ready 1, frame_err 0, synchronizer flops 1.
REQ-020 Reset mid-byte SHALL abort reception with no data update; the next full frame after release SHALL be received correctly.

Configuration
REQ-021 Macro UART_RX_PARITY_EN defined: SHALL add state PARITY between DATA and STOP sampling one even-parity bit, and output parity_err (1 bit, reset 0, updated with data at stop sample, high if XOR of 8 data bits and parity bit is 1).
REQ-022 Macro UART_RX_PARITY_EN undefined: SHALL have no PARITY state, no parity_err port; DATA goes directly to STOP.

Structure
REQ-023 SHALL place state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4) and the default CLKS_PER_BIT constant in shared package uart_pkg.
REQ-024 SHALL instantiate the synchronizer as sub-module sync2 (1-bit, reset value parameter, async active-low reset).

Verification (bench uses CLKS_PER_BIT=16)
REQ-025 Frame 8'hA5, stop=1 -> data=8'hA5, frame_err=0, one ready low->high transition, ready high 1 clk after stop-sample tick.
REQ-026 rxd low for 4 clks then high -> state returns IDLE, ready stays 1, data unchanged.
REQ-027 Frame 8'h3C with stop=0, rxd held low 40 clks -> data=8'h3C, frame_err=1, no second byte until rxd high then new start.
REQ-028 Back-to-back 8'h00 then 8'hFF, no idle gap -> two ready rising edges, data 8'h00 then 8'hFF, frame_err=0.
REQ-029 rst low during bit 3 of 8'h5A, then frame 8'h81 -> outputs at reset values, then data=8'h81.
REQ-030 With UART_RX_PARITY_EN, 8'h01 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
